// File: rtl/gain_array_pkg.sv
// Shared types for the gain array: channel mode encodings and the stage payload.
// No logic of its own; widths are upper bounds and users take the low slices.
// Not applicable (type-only package).
package gain_array_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS   = 2'b00,
      MODE_GAIN     = 2'b01,
      MODE_MUTE     = 2'b10,
      MODE_MUTE_ALT = 2'b11
   } mode_e;

   // Upper bounds for the payload fields; the top slices to its own DW / channel width.
   localparam int MAX_DW = 64;
   localparam int MAX_CW = 5;

   typedef struct packed {
      logic signed [MAX_DW-1:0] data;
      logic [MAX_CW-1:0]        ch;
      logic                     sat;
   } stage_t;

endpackage

// File: rtl/sat_round.sv
// Round-half-up by FRAC bits and saturate a signed product down to DW bits.
// Purely combinational, zero latency.
// No flow control; the caller registers the result.
module sat_round #(
   parameter int IW   = 24,
   parameter int DW   = 16,
   parameter int FRAC = 4
) (
   input  logic signed [IW-1:0] din,
   output logic signed [DW-1:0] dout,
   output logic                 sat
);

   // One extra bit so adding the rounding constant can never wrap.
   logic signed [IW:0]       biased;
   logic signed [IW:0]       shifted;
   logic        [IW-DW+1:0]  top_bits;

   assign biased   = {din[IW-1], din} + (IW+1)'(1 << (FRAC-1));
   assign shifted  = biased >>> FRAC;
   // Result fits in DW bits only if every bit from DW-1 upward is a sign copy.
   assign top_bits = shifted[IW:DW-1];
   assign sat      = !((&top_bits) || !(|top_bits));

   // Clamp toward the rail matching the sign of the true result.
   always_comb begin
      dout = shifted[DW-1:0];
      if (sat) begin
         dout = shifted[IW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/gain_array.sv
// Per-channel gain/bypass/mute on a time-multiplexed sample stream with sticky saturation flags.
// Latency 2 cycles (stage 1 multiply, stage 2 round/saturate) when not stalled.
// Whole pipeline advances only when the output slot is free or drained; in_ready equals that advance.
module gain_array
   import gain_array_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DW       = 16,
   parameter int GW       = 8,
   parameter int FRAC     = 4,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   input  logic [CW-1:0]        in_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_data,
   output logic [CW-1:0]        out_ch,
   output logic                 out_sat,
   input  logic                 cfg_we,
   input  logic [CW-1:0]        cfg_ch,
   input  logic [GW-1:0]        cfg_gain,
   input  logic [1:0]           cfg_mode,
   input  logic                 sat_clr,
   output logic [CHANNELS-1:0]  sat_status
);

   localparam int PW = DW + GW;

   logic signed [GW-1:0] gain_q [CHANNELS];
   mode_e                mode_q [CHANNELS];

   logic                 adv;
   logic                 in_ch_ok;
   mode_e                in_mode;
   logic signed [GW-1:0] in_gain;
   logic signed [PW-1:0] prod;

   logic                 s1_vld;
   logic signed [PW-1:0] s1_prod;
   mode_e                s1_mode;
   logic signed [DW-1:0] s1_data;
   logic [CW-1:0]        s1_ch;

   logic signed [DW-1:0] rnd_data;
   logic                 rnd_sat;
   stage_t               s2_d;
   stage_t               s2_q;
   logic                 s2_vld;

   logic [CHANNELS-1:0]  sat_set;
   logic                 unused_hi;

   assign adv      = !s2_vld || out_ready;
   assign in_ready = adv;

   // Configuration registers; out-of-range channel writes are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            gain_q[c] <= GW'(1 << FRAC);
            mode_q[c] <= MODE_BYPASS;
         end
      end else if (cfg_we && (32'(cfg_ch) < CHANNELS)) begin
         gain_q[cfg_ch] <= cfg_gain;
         mode_q[cfg_ch] <= mode_e'(cfg_mode);
      end
   end

   // Look up the sample's channel settings; an unknown channel behaves as mute.
   assign in_ch_ok = 32'(in_ch) < CHANNELS;
   always_comb begin
      in_mode = MODE_MUTE;
      in_gain = '0;
      if (in_ch_ok) begin
         in_mode = mode_q[in_ch];
         in_gain = gain_q[in_ch];
      end
   end

   assign prod = PW'(in_data) * PW'(in_gain);

   // Stage 1: capture the product and the mode seen at transfer time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_prod <= '0;
         s1_mode <= MODE_BYPASS;
         s1_data <= '0;
         s1_ch   <= '0;
      end else if (adv) begin
         s1_vld  <= in_valid;
         s1_prod <= prod;
         s1_mode <= in_mode;
         s1_data <= in_data;
         s1_ch   <= in_ch;
      end
   end

   sat_round #(
      .IW   (PW),
      .DW   (DW),
      .FRAC (FRAC)
   ) u_sat_round (
      .din  (s1_prod),
      .dout (rnd_data),
      .sat  (rnd_sat)
   );

   // Select the stage-2 result by mode; only gain mode can saturate.
   always_comb begin
      s2_d      = '0;
      s2_d.ch   = MAX_CW'(s1_ch);
      case (s1_mode)
         MODE_BYPASS: s2_d.data = MAX_DW'(s1_data);
         MODE_GAIN: begin
            s2_d.data = MAX_DW'(rnd_data);
            s2_d.sat  = rnd_sat;
         end
         default:     s2_d.data = '0;
      endcase
   end

   // Stage 2 / output register; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
         s2_q   <= '0;
      end else if (adv) begin
         s2_vld <= s1_vld;
         s2_q   <= s2_d;
      end
   end

   assign out_valid = s2_vld;
   assign out_data  = s2_q.data[DW-1:0];
   assign out_ch    = s2_q.ch[CW-1:0];
   assign out_sat   = s2_q.sat;
   assign unused_hi = ^{s2_q.data[MAX_DW-1:DW], s2_q.ch[MAX_CW-1:CW]};

   // Flag the channel of a saturated sample as it is handed to the consumer.
   always_comb begin
      sat_set = '0;
      if (s2_vld && out_ready && s2_q.sat) begin
         sat_set[out_ch] = 1'b1;
      end
   end

   // Sticky flags; a new saturation beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_status <= '0;
      end else begin
         sat_status <= (sat_clr ? '0 : sat_status) | sat_set;
      end
   end

endmodule
